uart_rx_buffer: RTL and testbench

Receive-side character buffer placed directly downstream of the UART receiver. It captures each completed character, with its parity-error and frame-error flags, into a DEPTH-entry show-ahead FIFO. It reports fill level, raises a threshold interrupt and a character-timeout interrupt, and flags overrun when the host drains too slowly.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_core.sv | 64 ++++++
 rtl/uart_rx_buffer.sv | 89 ++++++++
 tb/tb_uart_rx_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: character width and the per-character receive entry.
package uart_pkg;
    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;
endpackage

// File: rtl/uart_fifo_core.sv
// Generic show-ahead FIFO: head entry is read combinationally, pushes to a full
// FIFO are dropped unless a pop happens in the same cycle.
module uart_fifo_core #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [7:0],
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wr_entry,
    output entry_t        head,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          dropped
);
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign level   = level_q;
    assign head    = empty ? entry_t'('0) : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the empty mask hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= wr_entry;
    end
endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures completed characters with error flags into a
// FIFO and generates level, timeout and overrun status for the host.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int  DEPTH         = 8,
    parameter int  TIMEOUT_TICKS = 640,
    localparam int LW            = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   baud16_en,
    input  logic                   rx_ready,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   parity_err,
    input  logic                   frame_err,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_parity_err,
    output logic                   rd_frame_err,
    output logic                   empty,
    output logic                   full,
    output logic [LW-1:0]          level,
    input  logic [LW-1:0]          thresh,
    output logic                   irq_level,
    output logic                   irq_timeout,
    output logic                   overrun,
    input  logic                   clr_overrun
);
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic          rx_ready_q, rx_ready_d;
    logic          overrun_q, overrun_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop_eff, dropped;
    uart_entry_t   wr_entry, head;

    assign push     = rx_ready & ~rx_ready_q;
    assign wr_entry = '{frame_err: frame_err, parity_err: parity_err, data: rx_data};
    assign pop_eff  = rd_en & ~empty;

    uart_fifo_core #(
        .DEPTH   (DEPTH),
        .entry_t (uart_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (rd_en),
        .wr_entry (wr_entry),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .dropped  (dropped)
    );

    assign rd_data       = head.data;
    assign rd_parity_err = head.parity_err;
    assign rd_frame_err  = head.frame_err;
    assign irq_level     = (thresh != '0) && (level >= thresh);
    assign irq_timeout   = (count_q == CW'(TIMEOUT_TICKS));
    assign overrun       = overrun_q;

    always_comb begin
        rx_ready_d = rx_ready;
        overrun_d  = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (dropped)     overrun_d = 1'b1;
        count_d = count_q;
        if (push || pop_eff || empty)
            count_d = '0;
        else if (baud16_en && !irq_timeout)
            count_d = count_q + CW'(1);
    end

    // rx_ready_q resets high so a level held through reset is not seen as a new character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_q <= 1'b1;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with hand-computed expectations.
module tb_uart_rx_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud16_en = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       parity_err = 1'b0;
    logic       frame_err = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_parity_err, rd_frame_err, empty, full;
    logic [3:0] level;
    logic [3:0] thresh = 4'd0;
    logic       irq_level, irq_timeout, overrun;
    logic       clr_overrun = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .baud16_en     (baud16_en),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .empty         (empty),
        .full          (full),
        .level         (level),
        .thresh        (thresh),
        .irq_level     (irq_level),
        .irq_timeout   (irq_timeout),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] d, input logic pe, input logic fe);
        rx_data = d; parity_err = pe; frame_err = fe; rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        step();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] d);
        rx_data = d; parity_err = 1'b0; frame_err = 1'b0;
        rx_ready = 1'b1; rd_en = 1'b1;
        step();
        rx_ready = 1'b0; rd_en = 1'b0;
        step();
    endtask

    task automatic tick();
        baud16_en = 1'b1;
        step();
        baud16_en = 1'b0;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && empty == 1'b0; i++) pop_one();
    endtask

    initial begin
        // Reset with rx_ready held high: releasing must not create a push.
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {rd_frame_err, rd_parity_err}, 0);
        chk("rst_irqs", {irq_level, irq_timeout, overrun}, 0);
        rx_ready = 1'b0;
        step();

        // Basic order and flags.
        push_char(8'h5A, 1'b0, 1'b0);
        chk("p1_rd_data", rd_data, 8'h5A);
        chk("p1_level", level, 1);
        push_char(8'h00, 1'b1, 1'b0);
        push_char(8'h55, 1'b0, 1'b1);
        chk("p3_level", level, 3);
        chk("pop1_data", rd_data, 8'h5A);
        chk("pop1_flags", {rd_frame_err, rd_parity_err}, 0);
        pop_one();
        chk("pop2_data", rd_data, 8'h00);
        chk("pop2_flags", {rd_frame_err, rd_parity_err}, 1);
        pop_one();
        chk("pop3_data", rd_data, 8'h55);
        chk("pop3_flags", {rd_frame_err, rd_parity_err}, 2);
        pop_one();
        chk("pop3_empty", empty, 1);
        chk("pop3_rd_data", rd_data, 0);

        // Fill, overrun, push+pop while full, set-wins.
        for (int i = 0; i < 8; i++) push_char(8'h20 + 8'(i), 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_level", level, 8);
        chk("fill_ovr", overrun, 0);
        push_char(8'h11, 1'b0, 1'b0);
        chk("drop_ovr", overrun, 1);
        chk("drop_level", level, 8);
        chk("drop_head", rd_data, 8'h20);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("clr_ovr", overrun, 0);
        push_pop(8'h30);
        chk("pp_full_level", level, 8);
        chk("pp_full_ovr", overrun, 0);
        chk("pp_full_head", rd_data, 8'h21);
        rx_data = 8'h12; rx_ready = 1'b1; clr_overrun = 1'b1;
        step();
        rx_ready = 1'b0; clr_overrun = 1'b0;
        chk("set_wins_ovr", overrun, 1);
        step();
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("clr2_ovr", overrun, 0);
        for (int i = 0; i < 7; i++) begin
            chk("full_order", rd_data, 8'h21 + i);
            pop_one();
        end
        chk("full_order_last", rd_data, 8'h30);
        pop_one();
        chk("full_drained", empty, 1);

        // Threshold interrupt.
        thresh = 4'd4;
        for (int i = 0; i < 3; i++) push_char(8'h40 + 8'(i), 1'b0, 1'b0);
        chk("thr_3", irq_level, 0);
        push_char(8'h43, 1'b0, 1'b0);
        chk("thr_4", irq_level, 1);
        pop_one();
        chk("thr_pop", irq_level, 0);
        thresh = 4'd0;
        for (int i = 0; i < 5; i++) push_char(8'h50 + 8'(i), 1'b0, 1'b0);
        chk("thr0_level", level, 8);
        chk("thr0_irq", irq_level, 0);
        thresh = 4'd9;
        #1;
        chk("thr9_irq", irq_level, 0);
        thresh = 4'd0;
        drain();
        chk("thr_drained", empty, 1);

        // Character timeout.
        push_char(8'h66, 1'b0, 1'b0);
        for (int i = 0; i < 639; i++) tick();
        chk("to_639", irq_timeout, 0);
        tick();
        chk("to_640", irq_timeout, 1);
        tick();
        chk("to_sat", irq_timeout, 1);
        pop_one();
        chk("to_pop_clr", irq_timeout, 0);
        push_char(8'h67, 1'b0, 1'b0);
        for (int i = 0; i < 638; i++) tick();
        rx_data = 8'h68; rx_ready = 1'b1; baud16_en = 1'b1;
        step();
        rx_ready = 1'b0; baud16_en = 1'b0;
        step();
        for (int i = 0; i < 639; i++) tick();
        chk("to_restart_639", irq_timeout, 0);
        tick();
        chk("to_restart_640", irq_timeout, 1);
        drain();
        chk("to_drain_irq", irq_timeout, 0);

        // Pointer wrap: two entries in flight, 20 characters total.
        push_char(8'h00, 1'b0, 1'b0);
        push_char(8'h01, 1'b0, 1'b0);
        for (int i = 2; i < 20; i++) begin
            push_char(8'(i), 1'b0, 1'b0);
            chk("wrap_data", rd_data, i - 2);
            pop_one();
        end
        chk("wrap_level", level, 2);
        chk("wrap_tail", rd_data, 8'h12);

        // Asynchronous reset mid-stream with a push pending.
        push_char(8'h77, 1'b0, 1'b0);
        rx_data = 8'h78; rx_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_level", level, 0);
        chk("arst_rd_data", rd_data, 0);
        step();
        rst = 1'b0;
        step(); step();
        chk("arst_held_empty", empty, 1);
        chk("arst_ovr", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
